// File: rtl/noc_input_route_unit.sv
// noc_input_route_unit: router input-port stage between the per-port input FIFO
// and the switch allocator. It pops flits, computes the XY route on head flits
// and holds that route for the whole packet. Each flit is presented through a
// one-entry registered valid/ready stage together with a one-hot port request.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_fifo_empty        upstream FIFO empty flag
//   i_fifo_read_data    FIFO head data, valid while popping a non-empty FIFO
//   o_fifo_read         pop request (combinational)
//   o_flit              registered output flit
//   o_flit_valid        o_flit / o_port_req valid
//   i_out_ready         downstream accepts the presented flit this cycle
//   o_port_req          one-hot port: [0]=Local [1]=N [2]=E [3]=S [4]=W
//   o_pkt_cnt           tail/single flits accepted downstream (wraps)
//   o_err               one-cycle pulse after a malformed flit sequence
module noc_input_route_unit #(
  parameter int unsigned FLIT_WIDTH = 16,
  parameter int unsigned COORD_W    = 2,
  parameter int unsigned MY_X       = 1,
  parameter int unsigned MY_Y       = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_fifo_empty,
  input  logic [FLIT_WIDTH-1:0] i_fifo_read_data,
  output logic                  o_fifo_read,
  output logic [FLIT_WIDTH-1:0] o_flit,
  output logic                  o_flit_valid,
  input  logic                  i_out_ready,
  output logic [4:0]            o_port_req,
  output logic [CNT_W-1:0]      o_pkt_cnt,
  output logic                  o_err
);

  localparam int unsigned PORT_W = 5;

  localparam logic [1:0] TYPE_BODY   = 2'b00;
  localparam logic [1:0] TYPE_HEAD   = 2'b01;
  localparam logic [1:0] TYPE_TAIL   = 2'b10;
  localparam logic [1:0] TYPE_SINGLE = 2'b11;

  localparam logic [PORT_W-1:0] PORT_L = 5'b00001;
  localparam logic [PORT_W-1:0] PORT_N = 5'b00010;
  localparam logic [PORT_W-1:0] PORT_E = 5'b00100;
  localparam logic [PORT_W-1:0] PORT_S = 5'b01000;
  localparam logic [PORT_W-1:0] PORT_W_ = 5'b10000;

  localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [PORT_W-1:0]     route_q, route_d;
  logic [FLIT_WIDTH-1:0] flit_q;
  logic                  flit_valid_q;
  logic [PORT_W-1:0]     port_req_q;
  logic [CNT_W-1:0]      pkt_cnt_q;
  logic                  err_q, err_d;

  logic                  pop_c;
  logic                  fwd_c;
  logic [PORT_W-1:0]     fwd_route_c;
  logic [PORT_W-1:0]     xy_route_c;
  logic [1:0]            ftype_c;
  logic [COORD_W-1:0]    dest_x_c, dest_y_c;
  logic                  accept_c;

  // Pop whenever data is waiting and the output slot is free or draining now.
  assign pop_c    = rst_n & ~i_fifo_empty & (~flit_valid_q | i_out_ready);
  assign accept_c = flit_valid_q & i_out_ready;

  assign ftype_c  = i_fifo_read_data[FLIT_WIDTH-1:FLIT_WIDTH-2];
  assign dest_x_c = i_fifo_read_data[2*COORD_W-1:COORD_W];
  assign dest_y_c = i_fifo_read_data[COORD_W-1:0];

  // Dimension-ordered route: resolve X first, then Y.
  always_comb begin
    xy_route_c = PORT_L;
    if (dest_x_c > MY_X_C) begin
      xy_route_c = PORT_E;
    end else if (dest_x_c < MY_X_C) begin
      xy_route_c = PORT_W_;
    end else if (dest_y_c > MY_Y_C) begin
      xy_route_c = PORT_N;
    end else if (dest_y_c < MY_Y_C) begin
      xy_route_c = PORT_S;
    end
  end

  // Packet framing FSM: decides forwarding, route selection and errors per pop.
  always_comb begin
    state_d     = state_q;
    route_d     = route_q;
    fwd_c       = 1'b0;
    fwd_route_c = route_q;
    err_d       = 1'b0;
    if (pop_c) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (ftype_c)
            TYPE_HEAD: begin
              route_d     = xy_route_c;
              fwd_c       = 1'b1;
              fwd_route_c = xy_route_c;
              state_d     = ST_PKT;
            end
            TYPE_SINGLE: begin
              fwd_c       = 1'b1;
              fwd_route_c = xy_route_c;
            end
            default: begin
              // Body/tail without a head: dropped.
              err_d = 1'b1;
            end
          endcase
        end
        ST_PKT: begin
          unique case (ftype_c)
            TYPE_BODY: begin
              fwd_c = 1'b1;
            end
            TYPE_TAIL: begin
              fwd_c   = 1'b1;
              state_d = ST_IDLE;
            end
            TYPE_HEAD: begin
              // Truncated packet: start the new one on its own route.
              err_d       = 1'b1;
              route_d     = xy_route_c;
              fwd_c       = 1'b1;
              fwd_route_c = xy_route_c;
            end
            default: begin
              err_d       = 1'b1;
              fwd_c       = 1'b1;
              fwd_route_c = xy_route_c;
              state_d     = ST_IDLE;
            end
          endcase
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state and locked route.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // One-entry output stage; payload only changes on a forwarded pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_q       <= '0;
      port_req_q   <= '0;
      flit_valid_q <= 1'b0;
    end else if (fwd_c) begin
      flit_q       <= i_fifo_read_data;
      port_req_q   <= fwd_route_c;
      flit_valid_q <= 1'b1;
    end else if (i_out_ready) begin
      flit_valid_q <= 1'b0;
    end
  end

  // Packet counter (tail and single both have the type MSB set) and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_d;
      if (accept_c && flit_q[FLIT_WIDTH-1]) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_fifo_read  = pop_c;
  assign o_flit       = flit_q;
  assign o_flit_valid = flit_valid_q;
  assign o_port_req   = port_req_q;
  assign o_pkt_cnt    = pkt_cnt_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_noc_input_route_unit.sv
// Directed bench for noc_input_route_unit: a small array-based FIFO model feeds
// the DUT; every step checks outputs against hand-computed values.
module tb_noc_input_route_unit;

  localparam int unsigned FLIT_WIDTH = 16;
  localparam int unsigned CNT_W      = 16;

  logic                  clk;
  logic                  rst_n;
  logic                  fifo_empty;
  logic [FLIT_WIDTH-1:0] fifo_data;
  logic                  fifo_read;
  logic [FLIT_WIDTH-1:0] flit;
  logic                  flit_valid;
  logic                  out_ready;
  logic [4:0]            port_req;
  logic [CNT_W-1:0]      pkt_cnt;
  logic                  err;

  logic [FLIT_WIDTH-1:0] mem [0:31];
  int unsigned           wr_ptr;
  int unsigned           rd_ptr;

  int errors;
  int checks;

  noc_input_route_unit #(
    .FLIT_WIDTH(FLIT_WIDTH),
    .COORD_W   (2),
    .MY_X      (1),
    .MY_Y      (1),
    .CNT_W     (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_fifo_empty    (fifo_empty),
    .i_fifo_read_data(fifo_data),
    .o_fifo_read     (fifo_read),
    .o_flit          (flit),
    .o_flit_valid    (flit_valid),
    .i_out_ready     (out_ready),
    .o_port_req      (port_req),
    .o_pkt_cnt       (pkt_cnt),
    .o_err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: head word is visible combinationally, pointer advances on a pop.
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fifo_empty ? 16'hxxxx : mem[rd_ptr[4:0]];

  always @(posedge clk) begin
    if (fifo_read && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  task automatic push(input logic [FLIT_WIDTH-1:0] v);
    mem[wr_ptr[4:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] f,
                           input logic [4:0] p);
    check({tag, "_valid"}, 32'(flit_valid), 32'(v));
    check({tag, "_flit"}, 32'(flit), 32'(f));
    check({tag, "_port"}, 32'(port_req), 32'(p));
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    wr_ptr    = 0;
    rd_ptr    = 0;
    rst_n     = 1'b0;
    out_ready = 1'b0;

    // Reset with empty FIFO.
    repeat (3) tick();
    check("rst_read", 32'(fifo_read), 32'd0);
    check_out("rst", 1'b0, 16'h0000, 5'b00000);
    check("rst_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_read", 32'(fifo_read), 32'd0);
    check("idle_valid", 32'(flit_valid), 32'd0);

    // Single flit to (2,0) goes East.
    out_ready = 1'b1;
    push(16'hC008);
    #1;
    check("s1_read", 32'(fifo_read), 32'd1);
    tick();
    check_out("s1", 1'b1, 16'hC008, 5'b00100);
    check("s1_cnt0", 32'(pkt_cnt), 32'd0);
    tick();
    check("s1_drain", 32'(flit_valid), 32'd0);
    check("s1_cnt1", 32'(pkt_cnt), 32'd1);

    // Head/body/tail to (1,1) go Local, back to back.
    push(16'h4005);
    push(16'h0123);
    push(16'h8ABC);
    tick();
    check_out("p2_head", 1'b1, 16'h4005, 5'b00001);
    tick();
    check_out("p2_body", 1'b1, 16'h0123, 5'b00001);
    tick();
    check_out("p2_tail", 1'b1, 16'h8ABC, 5'b00001);
    check("p2_cnt_pre", 32'(pkt_cnt), 32'd1);
    tick();
    check("p2_drain", 32'(flit_valid), 32'd0);
    check("p2_cnt", 32'(pkt_cnt), 32'd2);
    check("p2_err", 32'(err), 32'd0);

    // Head to (1,2) goes North; output stalls for three cycles.
    out_ready = 1'b0;
    push(16'h4006);
    push(16'h0077);
    tick();
    check_out("p3_head", 1'b1, 16'h4006, 5'b00010);
    check("p3_stall_read0", 32'(fifo_read), 32'd0);
    tick();
    check_out("p3_hold1", 1'b1, 16'h4006, 5'b00010);
    check("p3_stall_read1", 32'(fifo_read), 32'd0);
    tick();
    check_out("p3_hold2", 1'b1, 16'h4006, 5'b00010);
    out_ready = 1'b1;
    #1;
    check("p3_resume_read", 32'(fifo_read), 32'd1);
    push(16'h8011);
    tick();
    check_out("p3_body", 1'b1, 16'h0077, 5'b00010);
    tick();
    check_out("p3_tail", 1'b1, 16'h8011, 5'b00010);
    tick();
    check("p3_drain", 32'(flit_valid), 32'd0);
    check("p3_cnt", 32'(pkt_cnt), 32'd3);
    check("p3_err", 32'(err), 32'd0);

    // Stray body in IDLE is dropped with an error; following single to (0,0) goes West.
    push(16'h0055);
    push(16'hC000);
    tick();
    check("p4_err1", 32'(err), 32'd1);
    check("p4_drop", 32'(flit_valid), 32'd0);
    tick();
    check("p4_err0", 32'(err), 32'd0);
    check_out("p4_single", 1'b1, 16'hC000, 5'b10000);
    tick();
    check("p4_cnt", 32'(pkt_cnt), 32'd4);
    check("p4_drain", 32'(flit_valid), 32'd0);

    // Head to (1,0) goes South; reset mid-packet discards everything.
    out_ready = 1'b0;
    push(16'h4004);
    tick();
    check_out("p5_head", 1'b1, 16'h4004, 5'b01000);
    push(16'h8000);
    #2;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    #1;
    check_out("p5_async", 1'b0, 16'h0000, 5'b00000);
    check("p5_rst_cnt", 32'(pkt_cnt), 32'd0);
    check("p5_rst_read", 32'(fifo_read), 32'd0);
    tick();
    check("p5_rst_read2", 32'(fifo_read), 32'd0);
    rst_n = 1'b1;
    #1;
    check("p5_tail_read", 32'(fifo_read), 32'd1);
    tick();
    check("p5_tail_err", 32'(err), 32'd1);
    check("p5_tail_drop", 32'(flit_valid), 32'd0);
    tick();
    check("p5_err_clear", 32'(err), 32'd0);
    check("p5_valid", 32'(flit_valid), 32'd0);
    check("p5_cnt", 32'(pkt_cnt), 32'd0);
    check("p5_empty", 32'(fifo_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_input_route_unit.md
Name: noc_input_route_unit

Overview:
- Router input-port stage that sits directly downstream of the per-port synchronous input FIFO.
- Pops flits from the FIFO and performs XY route computation on head flits.
- Locks the computed output port for the whole packet, and presents each flit with a one-hot port request through a one-entry registered valid/ready output stage toward the crossbar/switch allocator.
- Counts completed packets and flags malformed flit sequences.

Parameters:
- FLIT_WIDTH, 16, flit width in bits; must be >= 2*COORD_W+2
- COORD_W, 2, width of each destination coordinate field
- MY_X, 1, X coordinate of this router
- MY_Y, 1, Y coordinate of this router
- CNT_W, 16, width of the packet counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_fifo_empty  in  1  upstream FIFO empty flag
- i_fifo_read_data  in  FLIT_WIDTH  FIFO read data; valid combinationally only in a cycle where o_fifo_read=1 and i_fifo_empty=0
- o_fifo_read  out  1  pop request to FIFO
- o_flit  out  FLIT_WIDTH  registered output flit
- o_flit_valid  out  1  o_flit/o_port_req valid
- i_out_ready  in  1  downstream accepts flit this cycle
- o_port_req  out  5  one-hot output port: [0]=Local [1]=N [2]=E [3]=S [4]=W
- o_pkt_cnt  out  CNT_W  count of tail/single flits accepted downstream
- o_err  out  1  one-cycle pulse on malformed sequence

Behaviour:
- Flit type = flit[FLIT_WIDTH-1:FLIT_WIDTH-2]: 00 body, 01 head, 10 tail, 11 single (head+tail).
- Head/single fields: dest_x = flit[2*COORD_W-1:COORD_W], dest_y = flit[COORD_W-1:0].
- XY route, with unsigned compares:
  - dest_x > MY_X -> E
  - dest_x < MY_X -> W
  - otherwise dest_y > MY_Y -> N
  - otherwise dest_y < MY_Y -> S
  - otherwise Local
- Reset (async, rst_n low):
  - o_flit_valid=0, o_flit=0, o_port_req=0, o_pkt_cnt=0, o_err=0.
  - State=IDLE, route_q=0.
  - o_fifo_read is forced 0 while rst_n=0.
- Pop rule (combinational): o_fifo_read = rst_n & ~i_fifo_empty & (~o_flit_valid | i_out_ready). Data is captured on the same clock edge as the pop.
- Output register update on each edge:
  - Pop of a forwarded flit -> o_flit<=data, o_port_req<=route, o_flit_valid<=1.
  - Else if i_out_ready -> o_flit_valid<=0.
  - Else hold.
  - o_flit and o_port_req must stay stable while o_flit_valid=1 and i_out_ready=0.
- Throughput: 1 flit/cycle. A downstream accept and a new pop in the same cycle is legal and leaves no bubble.
- Latency: FIFO pop edge -> o_flit_valid high the next cycle.
- FSM states: IDLE (awaiting head), PKT (route locked). Transitions on a pop:
  - IDLE + head: route_q<=XY(data); forward with XY(data); -> PKT.
  - IDLE + single: forward with XY(data); stay IDLE.
  - IDLE + body/tail: drop the flit (no output load); o_err pulse; stay IDLE.
  - PKT + body: forward with route_q; stay PKT.
  - PKT + tail: forward with route_q; -> IDLE.
  - PKT + head: o_err pulse; recompute route_q; forward; stay PKT.
  - PKT + single: o_err pulse; forward with XY(data); -> IDLE.
- o_pkt_cnt increments when o_flit_valid & i_out_ready and the output flit type is tail or single. It wraps modulo 2^CNT_W.
- o_err is registered and high exactly one cycle after the offending pop.
- Reset asserted mid-packet: all state is discarded immediately. The output flit is lost, and the next flit must be a head to avoid o_err.

Test Plan:
- Reset, FIFO empty -> o_fifo_read=0, o_flit_valid=0, o_port_req=0, o_pkt_cnt=0 held indefinitely.
- Push single 0xC008 (dest 2,0), i_out_ready=1 -> pop, next cycle o_flit=0xC008, o_port_req=5'b00100 (E), o_pkt_cnt=1 one cycle after accept.
- Head 0x4005 (dest 1,1), body 0x0123, tail 0x8ABC back-to-back, ready=1 -> three consecutive valid cycles, all o_port_req=5'b00001 (Local), o_pkt_cnt +1, state returns IDLE.
- Head 0x4006 (dest 1,2) then body, with i_out_ready=0 for 3 cycles -> o_fifo_read=0 after the first pop, o_flit=0x4006/o_port_req=5'b00010 (N) stable; the body follows 1 cycle after ready rises.
- Body 0x0055 while IDLE -> popped, o_flit_valid stays 0, o_err=1 for exactly one cycle; a following single 0xC000 (dest 0,0) routes W (5'b10000).
- Head 0x4004 (dest 1,0 -> S) then rst_n pulsed low mid-packet -> outputs reset asynchronously; a subsequent tail 0x8000 gives o_err=1 and is not forwarded.
